// File: rtl/serial_add_sched_pkg.sv
// Shared constants for the nibble-serial adder scheduler: slice width,
// requester ids and FSM state encoding.
package serial_add_sched_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sched_ripple_carry_adder.sv
// 4-bit ripple-carry adder slice: s = a + b + cin, cout = carry out of bit 3.
module ripple_carry_adder
  import serial_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler running WIDTH-bit adds one nibble per
// cycle through a single shared 4-bit ripple-carry slice.
module serial_add_sched
  import serial_add_sched_pkg::*;
#(
  parameter  int unsigned NIB   = 4,
  localparam int unsigned WIDTH = SLICE_W * NIB
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             rr_last;
  logic             rr_seen;
  logic             gnt_any;
  logic             gnt_id;
  logic             accept;
  logic             last_nib;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout;

  // rr_seen distinguishes "no grant since reset" so requester 0 wins first.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = ID_REQ0;
    if (req0_valid && req1_valid)
      gnt_id = rr_seen ? ~rr_last : ID_REQ0;
    else if (req1_valid)
      gnt_id = ID_REQ1;
    req0_ready = (state == IDLE) && gnt_any && (gnt_id == ID_REQ0);
    req1_ready = (state == IDLE) && gnt_any && (gnt_id == ID_REQ1);
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned k = 0; k < NIB; k++) begin
      if (cnt == CW'(k)) begin
        sl_a = op_a[k*SLICE_W +: SLICE_W];
        sl_b = op_b[k*SLICE_W +: SLICE_W];
      end
    end
    last_nib = (cnt == CW'(NIB - 1));
  end

  ripple_carry_adder u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_cout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last_nib)  state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      rr_last   <= ID_REQ0;
      rr_seen   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= ID_REQ0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= (gnt_id == ID_REQ1) ? req1_a   : req0_a;
            op_b    <= (gnt_id == ID_REQ1) ? req1_b   : req0_b;
            carry   <= (gnt_id == ID_REQ1) ? req1_cin : req0_cin;
            cnt     <= '0;
            rsp_id  <= gnt_id;
            rr_last <= gnt_id;
            rr_seen <= 1'b1;
          end
        end
        RUN: begin
          for (int unsigned k = 0; k < NIB; k++) begin
            if (cnt == CW'(k))
              rsp_sum[k*SLICE_W +: SLICE_W] <= sl_s;
          end
          carry <= sl_cout;
          cnt   <= cnt + CW'(1);
          if (last_nib) begin
            rsp_cout  <= sl_cout;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched: scoreboard driven by accepts,
// vector table plus hand-written timing, arbitration, stall and reset cases.
module tb_serial_add_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NIB=4 instance
  logic        v0, r0, c0, v1, r1, c1;
  logic [15:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [15:0] rsp_sum;

  // NIB=1 instance
  logic        xv0, xr0, xc0, xv1, xr1, xc1;
  logic [3:0]  xa0, xb0, xa1, xb1;
  logic        x_rsp_valid, x_rsp_ready, x_rsp_cout, x_rsp_id;
  logic [3:0]  x_rsp_sum;

  serial_add_sched #(.NIB(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_a(a0), .req0_b(b0), .req0_cin(c0),
    .req1_valid(v1), .req1_ready(r1), .req1_a(a1), .req1_b(b1), .req1_cin(c1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  serial_add_sched #(.NIB(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(xv0), .req0_ready(xr0), .req0_a(xa0), .req0_b(xb0), .req0_cin(xc0),
    .req1_valid(xv1), .req1_ready(xr1), .req1_a(xa1), .req1_b(xb1), .req1_cin(xc1),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_sum(x_rsp_sum),
    .rsp_cout(x_rsp_cout), .rsp_id(x_rsp_id)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] sum;
    logic        cout;
  } rsp_t;

  rsp_t        sb[$];
  int          accept_cyc[$];
  logic        accept_id[$];
  int          cyc = 0;
  int          n_rsp = 0;
  logic [15:0] last_sum;
  logic        last_cout, last_id;

  always @(posedge clk) cyc++;

  function automatic rsp_t model(input logic id, input logic [15:0] a, input logic [15:0] b, input logic cin);
    rsp_t r;
    logic [16:0] full;
    full   = 17'(a) + 17'(b) + 17'(cin);
    r.id   = id;
    r.sum  = full[15:0];
    r.cout = full[16];
    return r;
  endfunction

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot", 32'(r0 & r1), 32'd0);
      if (v0 && r0) begin
        sb.push_back(model(1'b0, a0, b0, c0));
        accept_cyc.push_back(cyc);
        accept_id.push_back(1'b0);
      end
      if (v1 && r1) begin
        sb.push_back(model(1'b1, a1, b1, c1));
        accept_cyc.push_back(cyc);
        accept_id.push_back(1'b1);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d sum 0x%h, expected no response", rsp_id, rsp_sum);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          check("sb_id",   32'(rsp_id),   32'(e.id));
          check("sb_sum",  32'(rsp_sum),  32'(e.sum));
          check("sb_cout", 32'(rsp_cout), 32'(e.cout));
        end
        last_sum  = rsp_sum;
        last_cout = rsp_cout;
        last_id   = rsp_id;
        n_rsp++;
      end
    end
  end

  typedef struct {
    logic        id;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int n0, input string name);
    for (int t = 0; t < 30; t++) begin
      if (n_rsp > n0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s: got no response within 30 cycles, expected one", name);
  endtask

  initial begin
    int n0;
    int lat;
    logic got;
    logic [15:0] s_hold;
    logic c_hold, id_hold;

    vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[4] = '{1'b1, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[5] = '{1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vecs[6] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};

    v0 = 0; v1 = 0; a0 = '0; b0 = '0; c0 = 0; a1 = '0; b1 = '0; c1 = 0;
    xv0 = 0; xv1 = 0; xa0 = '0; xb0 = '0; xc0 = 0; xa1 = '0; xb1 = '0; xc1 = 0;
    rsp_ready = 1; x_rsp_ready = 1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_sum",   32'(rsp_sum),   0);
    check("rst_cout",  32'(rsp_cout),  0);
    check("rst_id",    32'(rsp_id),    0);
    check("rst_ready", 32'({r0, r1}),  0);
    check("rst_x_valid", 32'(x_rsp_valid), 0);
    rst_n = 1;
    step();

    // Latency: ready in cycle 0, rsp_valid in cycle 5
    a0 = 16'h1234; b0 = 16'h4321; c0 = 0; v0 = 1;
    n0 = n_rsp;
    @(negedge clk);
    check("t1_ready0", 32'(r0), 1);
    check("t1_ready1", 32'(r1), 0);
    @(posedge clk); #1; v0 = 0;
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = t; break; end
    end
    check("t1_latency", 32'(lat), 5);
    wait_rsp(n0, "t1_rsp");
    check("t1_sum", 32'(last_sum), 32'h5555);
    check("t1_cout", 32'(last_cout), 0);
    check("t1_id", 32'(last_id), 0);
    step();

    // Vector table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].id) begin a1 = vecs[i].a; b1 = vecs[i].b; c1 = vecs[i].cin; v1 = 1; end
      else            begin a0 = vecs[i].a; b0 = vecs[i].b; c0 = vecs[i].cin; v0 = 1; end
      n0 = n_rsp;
      got = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if ((vecs[i].id && r1) || (!vecs[i].id && r0)) begin got = 1; break; end
      end
      check("vec_accept", 32'(got), 1);
      @(posedge clk); #1; v0 = 0; v1 = 0;
      wait_rsp(n0, "vec_rsp");
      check("vec_sum",  32'(last_sum),  32'(vecs[i].sum));
      check("vec_cout", 32'(last_cout), 32'(vecs[i].cout));
      check("vec_id",   32'(last_id),   32'(vecs[i].id));
      step();
    end

    // Reset in the middle of RUN discards the operation
    a0 = 16'hFFFF; b0 = 16'hFFFF; c0 = 1; v0 = 1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (r0) begin got = 1; break; end
    end
    check("rst_run_accept", 32'(got), 1);
    @(posedge clk); #1; v0 = 0;
    step();
    step();
    #2;
    rst_n = 0;
    sb.delete();
    #1;
    check("rst_run_valid", 32'(rsp_valid), 0);
    check("rst_run_sum",   32'(rsp_sum),   0);
    check("rst_run_cout",  32'(rsp_cout),  0);
    check("rst_run_id",    32'(rsp_id),    0);
    check("rst_run_ready", 32'({r0, r1}),  0);
    step();
    rst_n = 1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("rst_run_no_rsp", 32'(rsp_valid), 0);
    end
    step();

    // Round robin with both requesters valid continuously
    a0 = 16'h0101; b0 = 16'h0202; c0 = 0;
    a1 = 16'hF000; b1 = 16'h1000; c1 = 1;
    accept_cyc.delete();
    accept_id.delete();
    n0 = n_rsp;
    v0 = 1; v1 = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (accept_cyc.size() >= 4) break;
    end
    @(posedge clk); #1; v0 = 0; v1 = 0;
    if (accept_cyc.size() < 4) begin
      checks++;
      errors++;
      $display("FAIL rr_accepts: got %0d accepts, expected 4", accept_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        check("rr_grant", 32'(accept_id[k]), 32'(k % 2));
        if (k > 0) check("rr_period", 32'(accept_cyc[k] - accept_cyc[k-1]), 6);
      end
    end
    wait_rsp(n0 + 3, "rr_rsp");
    check("rr_rsp_count", 32'(n_rsp - n0), 4);
    step();

    // Backpressure: rsp_ready low for 3 cycles in RESP, both requesters valid
    rsp_ready = 0;
    n0 = n_rsp;
    v0 = 1; v1 = 1;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    check("stall_valid", 32'(got), 1);
    s_hold = rsp_sum; c_hold = rsp_cout; id_hold = rsp_id;
    check("stall_id0", 32'(id_hold), 0);
    check("stall_ready_a", 32'({r0, r1}), 0);
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      check("stall_valid_hold", 32'(rsp_valid), 1);
      check("stall_sum",  32'(rsp_sum),  32'(s_hold));
      check("stall_cout", 32'(rsp_cout), 32'(c_hold));
      check("stall_id",   32'(rsp_id),   32'(id_hold));
      check("stall_ready_b", 32'({r0, r1}), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("stall_hs_ready", 32'({r0, r1}), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("stall_next_valid", 32'(rsp_valid), 0);
    check("stall_next_ready1", 32'(r1), 1);
    @(posedge clk); #1; v0 = 0; v1 = 0;
    wait_rsp(n0 + 1, "stall_rsp");
    check("stall_rsp_count", 32'(n_rsp - n0), 2);
    check("stall_last_id", 32'(last_id), 1);
    step();

    // NIB=1 instance
    xa0 = 4'hF; xb0 = 4'h1; xc0 = 0; xv0 = 1;
    @(negedge clk);
    check("n1_ready0", 32'(xr0), 1);
    @(posedge clk); #1; xv0 = 0;
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (x_rsp_valid) begin lat = t; break; end
    end
    check("n1_latency", 32'(lat), 2);
    check("n1_sum",  32'(x_rsp_sum),  0);
    check("n1_cout", 32'(x_rsp_cout), 1);
    check("n1_id",   32'(x_rsp_id),   0);
    step();
    @(negedge clk);
    check("n1_drop", 32'(x_rsp_valid), 0);
    step();

    xa1 = 4'h5; xb1 = 4'h6; xc1 = 1; xv1 = 1;
    @(negedge clk);
    check("n1_ready1", 32'(xr1), 1);
    @(posedge clk); #1; xv1 = 0;
    got = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (x_rsp_valid) begin got = 1; break; end
    end
    check("n1b_valid", 32'(got), 1);
    check("n1b_sum",  32'(x_rsp_sum),  32'hC);
    check("n1b_cout", 32'(x_rsp_cout), 0);
    check("n1b_id",   32'(x_rsp_id),   1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Shares one 4-bit ripple-carry adder slice between two requesters.
- Each request is a WIDTH = 4*NIB bit add, which the block runs one nibble per cycle, LSB nibble first.
- A carry register links the nibbles.
- Round-robin arbitration picks the requester; the result returns on a valid/ready response channel tagged with the requester id.
- Sits between the operand producers and the shared arithmetic slice in the datapath.

Parameters:
NIB, 4, operand width in nibbles (NIB >= 1); WIDTH = 4*NIB.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 accepted this cycle when valid&ready
req0_a  input  WIDTH  operand A, requester 0
req0_b  input  WIDTH  operand B, requester 0
req0_cin  input  1  carry-in, requester 0
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accepted this cycle when valid&ready
req1_a  input  WIDTH  operand A, requester 1
req1_b  input  WIDTH  operand B, requester 1
req1_cin  input  1  carry-in, requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result when valid&ready
rsp_sum  output  WIDTH  A+B+cin modulo 2^WIDTH
rsp_cout  output  1  carry out of bit WIDTH-1
rsp_id  output  1  requester that issued this result

Behaviour:

States: IDLE, RUN, RESP.
- State and all registers are cleared asynchronously on rst_n=0: state=IDLE, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, carry=0, nibble counter=0, rr pointer=0.
- rst_n=0 mid-operation discards the operation; no response is produced.

Arbitration (IDLE only):
- grant = requester 0 if only req0_valid; requester 1 if only req1_valid.
- If both are valid, grant goes to the requester not granted last (rr pointer). After reset, requester 0 wins.
- reqN_ready = (state==IDLE) & grant==N. It is combinational from both valids and never high outside IDLE.
- At most one ready is high per cycle.

Accept (IDLE, valid&ready):
- Latch a, b, cin of the granted requester into operand registers; carry := cin; counter := 0; rsp_id := grant.
- Update the rr pointer to the granted id. Go to RUN.

RUN (exactly NIB cycles):
- Each cycle feeds slice nibble k of A and B plus carry to the adder slice.
- Writes the slice sum into nibble k of the result register and updates carry := slice cout; k := k+1.
- After nibble NIB-1: rsp_cout := final carry; go to RESP.
- Counter width is max(1, clog2(NIB)).

RESP:
- rsp_valid=1. rsp_sum, rsp_cout and rsp_id are registered and held stable until rsp_ready=1.
- On handshake: rsp_valid drops next cycle; go to IDLE.
- No request is accepted in the handshake cycle.

Latency and throughput:
- Accept at edge T; rsp_valid first high in cycle T+NIB+1.
- Minimum issue period is NIB+2 cycles.
- Requests not granted simply wait; the block holds no queue.
- A requester dropping valid before acceptance is legal and has no effect.

Arithmetic:
- Unsigned modulo 2^WIDTH; cout is bit WIDTH of A+B+cin.
- No overflow flag.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, RESP), the nibble width constant 4, and the requester id constant for 0 and 1.
- One sub-module: the 4-bit adder slice is the existing ripple_carry_adder (a, b, cin -> s, cout), instantiated once.
- Arbiter, FSM, operand/result registers and carry register live in serial_add_sched.

Test Plan:
- NIB=4, only req0: a=0x1234, b=0x4321, cin=0 -> req0_ready high in cycle 0; rsp_valid at cycle 5; rsp_sum=0x5555, rsp_cout=0, rsp_id=0.
- Full carry ripple, NIB=4, req1: a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1. Repeat with a=0xFFFF, b=0x0000, cin=1 -> same result.
- Both requesters valid continuously with rsp_ready=1 -> grants 0,1,0,1. Each response id matches its grant; accepts are exactly 6 cycles apart.
- rsp_ready held low 3 cycles in RESP with both requesters valid -> rsp_sum/cout/id stable and both readys low. After rsp_ready=1, the next accept comes one cycle later.
- rst_n pulsed low during RUN cycle 2 -> all outputs 0 immediately; no response emitted. After release with both valid, requester 0 is granted first.
- NIB=1: a=0xF, b=0x1, cin=0 -> rsp_sum=0x0, rsp_cout=1, rsp_valid 2 cycles after accept.
